// File: rtl/fft_peak_if.sv
// FFT output bus: one-cycle frame strobe with all bins in parallel, plus the
// peak-detector result signals going back to the top level.
interface fft_peak_if #(
  parameter int HALF_W = 16,
  parameter int NBINS  = 16
);
  localparam int IW = $clog2(NBINS);

  logic                                fft_valid;
  logic [NBINS-1:0][2*HALF_W-1:0]      fft_d;     // bin k: [31:16] re, [15:0] im
  logic                                done;
  logic [IW-1:0]                       freq;
  logic                                overrun;

  modport master (output fft_valid, fft_d, input  done, freq, overrun);
  modport slave  (input  fft_valid, fft_d, output done, freq, overrun);
endinterface

// File: rtl/fft_peak_detector.sv
// Latches a frame of NBINS complex bins, scans them one per clock and reports
// the index of the bin with the largest re^2+im^2 (ties keep the lower index).
module fft_peak_detector #(
  parameter int HALF_W = 16,
  parameter int NBINS  = 16
) (
  input  logic      clk,
  input  logic      rst,
  fft_peak_if.slave bus
);
  localparam int W  = 2 * HALF_W;
  localparam int IW = $clog2(NBINS);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [NBINS-1:0][W-1:0]    bank_q, bank_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [W-1:0]               best_mag_q, best_mag_d;
  logic [IW-1:0]              best_idx_q, best_idx_d;
  logic [IW-1:0]              freq_q, freq_d;
  logic                       done_q, done_d;
  logic                       overrun_q, overrun_d;

  logic [W-1:0]               cur;
  logic signed [HALF_W-1:0]   re, im;
  logic signed [W-1:0]        re_sq, im_sq;
  logic [W-1:0]               mag;
  logic                       last, capture, better;
  logic [W-1:0]               win_mag;
  logic [IW-1:0]              win_idx;

  // Squares are each <= 2^30, so their unsigned sum (<= 2^31) fits in W bits.
  assign cur   = bank_q[idx_q];
  assign re    = cur[W-1:HALF_W];
  assign im    = cur[HALF_W-1:0];
  assign re_sq = W'(re) * W'(re);
  assign im_sq = W'(im) * W'(im);
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

  assign last    = (state_q == S_SCAN) && (idx_q == IW'(NBINS - 1));
  assign capture = bus.fft_valid && ((state_q == S_IDLE) || last);
  assign better  = mag > best_mag_q;
  assign win_mag = better ? mag   : best_mag_q;
  assign win_idx = better ? idx_q : best_idx_q;

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    idx_d      = idx_q;
    best_mag_d = best_mag_q;
    best_idx_d = best_idx_q;
    freq_d     = freq_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;

    if (state_q == S_SCAN) begin
      best_mag_d = win_mag;
      best_idx_d = win_idx;
      idx_d      = idx_q + 1'b1;
      if (last) begin
        freq_d  = win_idx;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else if (bus.fft_valid) begin
        overrun_d = 1'b1;
      end
    end

    // Capture overrides the completion defaults; bin 15 was already read from bank_q.
    if (capture) begin
      bank_d     = bus.fft_d;
      state_d    = S_SCAN;
      idx_d      = '0;
      best_mag_d = '0;
      best_idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bank_q     <= '0;
      idx_q      <= '0;
      best_mag_q <= '0;
      best_idx_q <= '0;
      freq_q     <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      idx_q      <= idx_d;
      best_mag_q <= best_mag_d;
      best_idx_q <= best_idx_d;
      freq_q     <= freq_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.done    = done_q;
  assign bus.freq    = freq_q;
  assign bus.overrun = overrun_q;
endmodule
